// File: rtl/riscv_fetch_queue.sv
// rtl/riscv_fetch_queue.sv - rv32i instruction prefetch queue with AXI4-lite reads, redirect flush and halt/PC override
// Optional feature: FETCH_MISALIGN_CHECK_EN reports misaligned redirect/override targets as error entries.
module riscv_fetch_queue #(
    parameter int          ADDR_WIDTH      = 32,
    parameter int          DATA_WIDTH      = 32,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_err,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  halted,
    input  logic                  pc_we,
    input  logic [ADDR_WIDTH-1:0] pc_write_data,
    output logic [ADDR_WIDTH-1:0] fetch_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = 4;
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  ar_stale_q, ar_stale_d;
    logic [OW-1:0]         outstanding_q, outstanding_d;
    logic [OW-1:0]         discard_q, discard_d;
    logic                  stopped_q, stopped_d;
    logic                  halted_q, halted_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_pc_d [DEPTH];
    logic                  mem_err_q [DEPTH];
    logic                  mem_err_d [DEPTH];
    logic [ADDR_WIDTH-1:0] tag_q [MAX_OUTSTANDING];
    logic [ADDR_WIDTH-1:0] tag_d [MAX_OUTSTANDING];
    logic [TW-1:0]         tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic                  ar_hs, r_hs, push, pop, pc_we_eff, flush, misalign, issue_ok;
    logic [ADDR_WIDTH-1:0] target_raw, target;
    logic                  unused_low_bits;

    assign target_raw = redirect_valid ? redirect_pc : pc_write_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign target          = target_raw;
    assign misalign        = flush & (target_raw[1:0] != 2'b00);
    assign unused_low_bits = 1'b0;
`else
    assign target          = {target_raw[ADDR_WIDTH-1:2], 2'b00};
    assign misalign        = 1'b0;
    assign unused_low_bits = ^target_raw[1:0];
`endif

    always_comb begin
        ar_hs     = ar_valid_q & M_AXI_ARREADY;
        r_hs      = M_AXI_RVALID;
        pop       = (count_q != '0) & instr_ready;
        pc_we_eff = pc_we & halted_q;
        flush     = redirect_valid | pc_we_eff;
        push      = r_hs & (discard_q == '0) & ~flush;

        fetch_pc_d    = fetch_pc_q;
        ar_addr_d     = ar_addr_q;
        ar_valid_d    = ar_valid_q;
        ar_stale_d    = ar_stale_q;
        stopped_d     = stopped_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mem_data_d    = mem_data_q;
        mem_pc_d      = mem_pc_q;
        mem_err_d     = mem_err_q;
        tag_d         = tag_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        outstanding_d = outstanding_q + OW'(ar_hs) - OW'(r_hs);
        count_d       = count_q + CW'(push) - CW'(pop);

        // Tags follow every accepted AR and every R beat, stale or not, so order is kept.
        if (ar_hs) begin
            tag_d[tag_wr_q] = ar_addr_q;
            tag_wr_d        = (tag_wr_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr_q + 1'b1;
            ar_stale_d      = 1'b0;
            if (!ar_stale_q) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
        end
        if (r_hs) begin
            tag_rd_d = (tag_rd_q == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd_q + 1'b1;
            if (discard_q != '0) discard_d = discard_q - 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push) begin
            mem_data_d[wr_ptr_q] = M_AXI_RDATA;
            mem_pc_d[wr_ptr_q]   = tag_q[tag_rd_q];
            mem_err_d[wr_ptr_q]  = (M_AXI_RRESP != 2'b00);
            wr_ptr_d             = wr_ptr_q + 1'b1;
            if (M_AXI_RRESP != 2'b00) stopped_d = 1'b1;
        end

        if (flush) begin
            fetch_pc_d = target;
            stopped_d  = misalign;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            if (redirect_valid) begin
                // A held AR that is not accepted now will still be answered later: drop that too.
                discard_d = outstanding_q + OW'(ar_valid_q) - OW'(r_hs);
                if (ar_valid_q && !M_AXI_ARREADY) ar_stale_d = 1'b1;
            end
            if (misalign) begin
                mem_data_d[0] = '0;
                mem_pc_d[0]   = target;
                mem_err_d[0]  = 1'b1;
                wr_ptr_d      = PW'(1);
                count_d       = CW'(1);
            end
        end

        issue_ok = ~halt & ~stopped_d
                 & (32'(outstanding_d) < MAX_OUTSTANDING)
                 & ((32'(count_d) + 32'(outstanding_d)) < (DEPTH + 32'(discard_d)));
        if (!ar_valid_q || ar_hs) begin
            ar_valid_d = issue_ok;
            if (issue_ok) ar_addr_d = fetch_pc_d;
        end

        halted_d = halt & (outstanding_d == '0) & ~ar_valid_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            fetch_pc_q    <= ADDR_WIDTH'(BOOT_ADDR);
            ar_addr_q     <= ADDR_WIDTH'(BOOT_ADDR);
            ar_valid_q    <= 1'b0;
            ar_stale_q    <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
            stopped_q     <= 1'b0;
            halted_q      <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_pc_q[i]   <= '0;
                mem_err_q[i]  <= 1'b0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            ar_addr_q     <= ar_addr_d;
            ar_valid_q    <= ar_valid_d;
            ar_stale_q    <= ar_stale_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            stopped_q     <= stopped_d;
            halted_q      <= halted_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            mem_data_q    <= mem_data_d;
            mem_pc_q      <= mem_pc_d;
            mem_err_q     <= mem_err_d;
            tag_q         <= tag_d;
        end
    end

    assign M_AXI_ARVALID = ar_valid_q;
    assign M_AXI_ARADDR  = ar_addr_q;
    assign M_AXI_ARPROT  = 3'b100;
    assign M_AXI_RREADY  = 1'b1;
    assign instr_valid   = (count_q != '0);
    assign instr_data    = mem_data_q[rd_ptr_q];
    assign instr_pc      = mem_pc_q[rd_ptr_q];
    assign instr_err     = mem_err_q[rd_ptr_q];
    assign halted        = halted_q;
    assign fetch_pc      = fetch_pc_q;
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// tb/tb_riscv_fetch_queue.sv - scoreboard bench for riscv_fetch_queue with an in-order AXI4-lite read slave
module tb_riscv_fetch_queue;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        arvalid, arready, rvalid, rready, instr_valid, instr_ready, instr_err;
    logic        redirect_valid, halt, halted, pc_we;
    logic [31:0] araddr, rdata, instr_data, instr_pc, redirect_pc, pc_write_data, fetch_pc;
    logic [2:0]  arprot;
    logic [1:0]  rresp;

    always #5 CLK = ~CLK;

    riscv_fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .MAX_OUTSTANDING(2),
                        .BOOT_ADDR(32'h0000_0100)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
        .instr_pc(instr_pc), .instr_err(instr_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .halted(halted), .pc_we(pc_we), .pc_write_data(pc_write_data), .fetch_pc(fetch_pc)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] data; logic err; } exp_t;
    typedef struct { logic [31:0] addr; int due; } rq_t;

    exp_t        exp_q[$];
    rq_t         slv_q[$];
    logic [31:0] ar_log[$];
    int          n_checks = 0, n_fail = 0, delivered = 0, cycle = 0, lat = 1, last_cyc = 0, base = 0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    bit          tput_on = 1'b0, have_last = 1'b0;
    exp_t        got, want;

    always @(posedge CLK) cycle <= cycle + 1;

    // Slave: accepts every AR, answers in order after lat cycles.
    always @(negedge CLK) begin
        if (!RSTn) begin
            slv_q.delete();
            rvalid = 1'b0;
        end else begin
            if (rvalid && rready) void'(slv_q.pop_front());
            if (arvalid && arready) begin
                ar_log.push_back(araddr);
                slv_q.push_back('{araddr, cycle + lat});
            end
            if (slv_q.size() > 0 && slv_q[0].due <= cycle) begin
                rvalid = 1'b1;
                rdata  = slv_q[0].addr ^ 32'hA5A5_0000;
                rresp  = (slv_q[0].addr == err_addr) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTn && instr_valid && instr_ready) begin
            got = {instr_pc, instr_data, instr_err};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL deliver_unexpected: got pc=%h data=%h err=%b, expected no delivery",
                         instr_pc, instr_data, instr_err);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL deliver: got pc=%h data=%h err=%b, expected pc=%h data=%h err=%b",
                             instr_pc, instr_data, instr_err, want.pc, want.data, want.err);
                end
            end
            if (tput_on) begin
                if (have_last) begin
                    n_checks++;
                    if (cycle != last_cyc + 1) begin
                        n_fail++;
                        $display("FAIL throughput: got gap %0d cycles, expected 1", cycle - last_cyc);
                    end
                end
                have_last = 1'b1;
                last_cyc  = cycle;
            end
            delivered++;
        end
    end

    task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] want_v);
        n_checks++;
        if (got_v !== want_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got_v, want_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic push_seq(input int n, input logic [31:0] pc0);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = pc0 + 32'(4 * i);
            exp_q.push_back('{pc, pc ^ 32'hA5A5_0000, pc == err_addr});
        end
    endtask

    task automatic run_ready(input int n);
        int target;
        target      = delivered + n;
        instr_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge CLK);
            #1;
            if (delivered >= target) break;
        end
        instr_ready = 1'b0;
        n_checks++;
        if (delivered < target) begin
            n_fail++;
            $display("FAIL delivery_timeout: got %0d deliveries, expected %0d", delivered - target + n, n);
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        arready = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        halt = 1'b0; pc_we = 1'b0; pc_write_data = '0; rvalid = 1'b0; rdata = '0; rresp = '0;
        tick(3);
        check("rst_arvalid", 32'(arvalid), 32'd0);
        check("rst_araddr", araddr, 32'h100);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_data", instr_data, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_instr_err", 32'(instr_err), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fetch_pc", fetch_pc, 32'h100);
        check("arprot", 32'(arprot), 32'd4);
        RSTn = 1'b1;
        tick(1);
        check("first_arvalid", 32'(arvalid), 32'd1);
        check("first_araddr", araddr, 32'h100);

        tput_on = 1'b1;
        push_seq(8, 32'h100);
        run_ready(8);
        tput_on = 1'b0;

        tick(10);
        check("stall_arvalid", 32'(arvalid), 32'd0);
        check("stall_ar_count", 32'(ar_log.size()), 32'd12);
        check("stall_head_pc", instr_pc, 32'h120);
        lat = 3;
        push_seq(8, 32'h120);
        run_ready(8);

        tick(15);
        redirect(32'h1F0);
        check("redir_arvalid", 32'(arvalid), 32'd1);
        check("redir_araddr", araddr, 32'h1F0);
        tick(1);
        redirect(32'h200);
        push_seq(8, 32'h200);
        run_ready(8);

        tick(15);
        lat = 1;
        tick(5);
        err_addr = 32'h108;
        base = ar_log.size();
        redirect(32'h100);
        push_seq(4, 32'h100);
        run_ready(4);
        tick(10);
        check("err_ar_count", 32'(ar_log.size() - base), 32'd4);
        check("err_arvalid", 32'(arvalid), 32'd0);
        check("err_instr_valid", 32'(instr_valid), 32'd0);
        redirect(32'h300);
        push_seq(4, 32'h300);
        run_ready(4);

        tick(10);
        halt = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (halted) break;
            tick(1);
        end
        check("halted", 32'(halted), 32'd1);
        pc_we = 1'b1;
        pc_write_data = 32'h400;
        tick(1);
        pc_we = 1'b0;
        check("pc_we_fetch_pc", fetch_pc, 32'h400);
        check("pc_we_flush", 32'(instr_valid), 32'd0);
        push_seq(4, 32'h400);
        base = ar_log.size();
        halt = 1'b0;
        run_ready(4);
        if (ar_log.size() > base) check("resume_araddr", ar_log[base], 32'h400);
        else check("resume_ar_count", 32'(ar_log.size()), 32'(base + 1));
        tick(10);
        check("pre_ignore_fetch_pc", fetch_pc, 32'h420);
        pc_we = 1'b1;
        pc_write_data = 32'h500;
        tick(1);
        pc_we = 1'b0;
        check("ignored_pc_we", fetch_pc, 32'h420);
        check("ignored_head_pc", instr_pc, 32'h410);
        push_seq(4, 32'h410);
        run_ready(4);

        tick(10);
        redirect(32'h202);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("misalign_arvalid", 32'(arvalid), 32'd0);
        check("misalign_valid", 32'(instr_valid), 32'd1);
        exp_q.push_back('{32'h202, 32'h0, 1'b1});
        run_ready(1);
        tick(5);
        check("misalign_no_ar", 32'(arvalid), 32'd0);
        check("misalign_empty", 32'(instr_valid), 32'd0);
`else
        check("align_arvalid", 32'(arvalid), 32'd1);
        check("align_araddr", araddr, 32'h200);
        push_seq(2, 32'h200);
        run_ready(2);
`endif
        tick(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_fetch_queue.md
# riscv_fetch_queue

Parametrised instruction-fetch front end for the rv32i core. It generates sequential PCs, issues up to `MAX_OUTSTANDING` pipelined AXI4-lite reads, and buffers returned words with their PCs in a `DEPTH`-entry FIFO. Instructions are delivered to decode over a valid/ready channel. It sits between the core's PC/decode logic and the memory arbiter's instruction port, and adds prefetch, redirect flush and halt/PC-override for the SOC control module.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: fetch address width.
- `DATA_WIDTH`, default 32: instruction word width.
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `MAX_OUTSTANDING`, default 2: in-flight AR requests. Must satisfy 1 ≤ `MAX_OUTSTANDING` ≤ `DEPTH` and ≤ 15.
- `BOOT_ADDR`, default 32'h0000_0000: PC after reset.

Ports:
- `CLK`, in, 1: clock. One clock domain.
- `RSTn`, in, 1: asynchronous, active-low reset.
- `M_AXI_ARVALID` out 1, `M_AXI_ARREADY` in 1, `M_AXI_ARADDR` out `ADDR_WIDTH`, `M_AXI_ARPROT` out 3: read address channel. `ARPROT` is constant 3'b100 (instruction).
- `M_AXI_RVALID` in 1, `M_AXI_RREADY` out 1, `M_AXI_RDATA` in `DATA_WIDTH`, `M_AXI_RRESP` in 2: read data channel.
- `instr_valid` out 1, `instr_ready` in 1: delivery handshake.
- `instr_data` out `DATA_WIDTH`, `instr_pc` out `ADDR_WIDTH`, `instr_err` out 1: head entry. `instr_err` is set when RRESP ≠ OKAY.
- `redirect_valid` in 1, `redirect_pc` in `ADDR_WIDTH`: branch/jump target from execute.
- `halt` in 1: stop issuing new fetches (SOC control module).
- `halted` out 1: high when `halt`=1, nothing is in flight, and ARVALID=0.
- `pc_we` in 1, `pc_write_data` in `ADDR_WIDTH`, `fetch_pc` out `ADDR_WIDTH`: control-module PC override and readback.

## Operation
State:
- `fetch_pc`: next address to request.
- `outstanding`: accepted AR count with no R yet.
- `discard`: responses still to drop.
- `stopped`: flag.
- FIFO with `count`, `rd_ptr`, `wr_ptr`.

AR issue:
- ARVALID is asserted when all of the following hold:
  - `halt`=0 and `stopped`=0;
  - `outstanding` < `MAX_OUTSTANDING`;
  - `count` + `outstanding` − `discard` < `DEPTH` (space reservation).
- ARADDR = `fetch_pc`.
- Once ARVALID is high, it and ARADDR are held until ARREADY, regardless of redirect or halt (AXI rule).
- On the AR handshake: `fetch_pc` += 4 and `outstanding` += 1.

R response:
- RREADY is tied to 1. Space is guaranteed by the reservation rule.
- On RVALID: `outstanding` −= 1.
- If `discard` > 0: drop the response and decrement `discard`.
- Otherwise: push {RDATA, PC tag, RRESP≠0} into the FIFO.
- The PC tag comes from a small in-order tag queue of depth `MAX_OUTSTANDING`, written on the AR handshake.
- A pushed entry with the error bit set sets `stopped`. No further AR is issued until the next redirect.

Redirect (`redirect_valid`=1):
- The FIFO is flushed.
- `discard` is set to the number of requests in flight, including any AR that is being accepted in the same cycle or is still pending.
- `fetch_pc` = `redirect_pc`; `stopped` is cleared.
- A delivery handshake in the same cycle still completes. Redirect otherwise has priority over push and pop.
- An R beat arriving in the redirect cycle is dropped.

Halt and PC override:
- `halt` blocks new AR issue only. In-flight reads complete and are enqueued normally.
- `pc_we` takes effect only while `halted`=1. It loads `fetch_pc`, flushes the FIFO and clears `stopped`.
- Outside `halted`, `pc_we` is ignored.

FIFO arithmetic:
- Pointers are log2(`DEPTH`) bits and wrap modulo `DEPTH`.
- Push and pop in the same cycle leave `count` unchanged. This also applies when the FIFO is full, because the pop frees the slot.

## Timing
Reset values:
- ARVALID=0, ARADDR=`BOOT_ADDR`.
- `instr_valid`=0, `instr_data`=0, `instr_pc`=0, `instr_err`=0.
- `halted`=0 (until the first evaluation), `fetch_pc`=`BOOT_ADDR`.
- All counters and the FIFO are cleared.

Latencies:
- ARVALID rises in the first cycle after `RSTn` deasserts.
- An R beat accepted in cycle N gives `instr_valid`=1 in cycle N+1. FIFO outputs are registered, so there is no combinational RDATA→`instr_data` path.
- A redirect in cycle N gives ARVALID with the new address in cycle N+1, unless an old AR is still pending.
- With a zero-wait-state slave, steady-state throughput is one instruction per cycle when `MAX_OUTSTANDING` ≥ 2.

Handshake rule: while `instr_valid`=1 and `instr_ready`=0, the outputs are held stable.

Reset mid-transaction: all state clears immediately. The slave side is reset together with the core.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect or `pc_we` to an address with bits [1:0] ≠ 0 issues no AR.
  - It flushes the FIFO, pushes one entry {data=0, pc=target, err=1} the next cycle, and sets `stopped`.
- Not defined:
  - Bits [1:0] of the redirect or written PC are forced to 00.
  - No misalignment is ever reported.

## Test plan
- Reset, `BOOT_ADDR`=0x100, zero-wait slave returning mem[a]=a^0xA5A5_0000 → ARADDR sequence 0x100, 0x104, 0x108…; `instr_pc`/`instr_data` delivered in order at one instruction per cycle.
- `instr_ready`=0 held for 10 cycles → exactly `DEPTH` entries buffered; ARVALID low; `outstanding`=0; no response lost after release.
- Redirect to 0x200 with 2 reads in flight and a 3-cycle slave latency → both stale responses dropped; the next `instr_pc` is 0x200.
- RRESP=SLVERR at 0x108 → entry delivered with `instr_err`=1; no AR after it; redirect to 0x300 resumes fetching.
- `halt`=1, wait for `halted`, `pc_we` with 0x400, `halt`=0 → `fetch_pc` reads 0x400 and the first ARADDR is 0x400. `pc_we` while not halted → ignored.
- Redirect to 0x202: with the macro → one `instr_err`=1 entry, pc=0x202, no AR. Without the macro → ARADDR=0x200.
